sample_packer: RTL

SAMPLE_PACKER -- requirements
Module: sample_packer

---
 rtl/sqd_acq_pkg.sv | 23 ++
 rtl/sample_packer_if.sv | 25 ++
 rtl/sample_fifo.sv | 57 +++++
 rtl/sample_packer.sv | 116 +++++++++++
 4 files changed

// File: rtl/sqd_acq_pkg.sv
// Shared acquisition-path definitions: sample/word/address widths, the
// FIFO entry layout and the sample extension helper.
package sqd_acq_pkg;

    localparam int ADC_WIDTH  = 14;
    localparam int WORD_WIDTH = 32;
    localparam int ADDR_WIDTH = 32;
    localparam int HALF_WIDTH = WORD_WIDTH / 2;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [WORD_WIDTH-1:0] data;
    } fifo_entry_t;

    // Widen one ADC sample to a half word, either sign- or zero-extended.
    function automatic logic [HALF_WIDTH-1:0] ext_sample(input logic [ADC_WIDTH-1:0] s,
                                                         input logic                 sign_en);
        logic w_fill;
        w_fill = sign_en & s[ADC_WIDTH-1];
        return {{(HALF_WIDTH-ADC_WIDTH){w_fill}}, s};
    endfunction

endpackage

// File: rtl/sample_packer_if.sv
// Sample-in / word-out bus of the sample packer. slave is the packer's view,
// master is the view of whoever drives samples and accepts words.
interface sample_packer_if;
    import sqd_acq_pkg::*;

    logic                  in_valid;
    logic [ADDR_WIDTH-1:0] in_addr;
    logic [ADC_WIDTH-1:0]  in_data_a;
    logic [ADC_WIDTH-1:0]  in_data_b;
    logic                  out_valid;
    logic                  out_ready;
    logic [ADDR_WIDTH-1:0] out_addr;
    logic [WORD_WIDTH-1:0] out_data;

    modport slave (
        input  in_valid, in_addr, in_data_a, in_data_b, out_ready,
        output out_valid, out_addr, out_data
    );

    modport master (
        output in_valid, in_addr, in_data_a, in_data_b, out_ready,
        input  out_valid, out_addr, out_data
    );

endinterface

// File: rtl/sample_fifo.sv
// Synchronous FIFO with combinational head read and occupancy output.
// DEPTH must be a power of two so the pointers wrap on their own.
module sample_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_wr_en,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_rd_en,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             w_full;
    logic             w_do_wr;
    logic             w_do_rd;

    assign o_empty   = (r_level == '0);
    assign w_full    = (r_level == LW'(DEPTH));
    assign w_do_rd   = i_rd_en && !o_empty;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign w_do_wr   = i_wr_en && (!w_full || w_do_rd);
    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_level   = r_level;

    // Storage array, written at the tail.
    always_ff @(posedge clk) begin
        if (w_do_wr) r_mem[r_wr_ptr] <= i_wr_data;
    end

    // Pointers and occupancy; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_wr, w_do_rd})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/sample_packer.sv
// Packs two 14-bit ADC samples into one 32-bit memory word {ext(B), ext(A)},
// buffers words in sample_fifo and presents them through one output register.
// Optional statistics counters are built when SAMPLE_PACKER_STATS_EN is defined.
module sample_packer
    import sqd_acq_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int SIGN_EXT   = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    sample_packer_if.slave              bus,
    input  logic                        clear_overflow,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        overflow
`ifdef SAMPLE_PACKER_STATS_EN
    ,
    output logic [31:0]                 words_out,
    output logic [15:0]                 drops
`endif
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    fifo_entry_t           w_in_entry;
    fifo_entry_t           w_head;
    logic                  w_fifo_empty;
    logic [LW-1:0]         w_fifo_level;
    logic [LW-1:0]         w_total;
    logic                  w_xfer;
    logic                  w_accept;
    logic                  w_drop;
    logic                  w_load;

    logic                  r_out_valid;
    logic [ADDR_WIDTH-1:0] r_out_addr;
    logic [WORD_WIDTH-1:0] r_out_data;
    logic                  r_overflow;

    assign w_in_entry.addr = bus.in_addr;
    assign w_in_entry.data = {ext_sample(bus.in_data_b, SIGN_EXT != 0),
                              ext_sample(bus.in_data_a, SIGN_EXT != 0)};

    // The output register counts toward capacity, so FIFO + register never
    // hold more than FIFO_DEPTH words.
    assign w_total  = w_fifo_level + LW'(r_out_valid);
    assign w_xfer   = r_out_valid && bus.out_ready;
    assign w_accept = bus.in_valid && ((w_total < LW'(FIFO_DEPTH)) || w_xfer);
    assign w_drop   = bus.in_valid && !w_accept;
    // Refill the output register whenever it is empty or being emptied.
    assign w_load   = !w_fifo_empty && (!r_out_valid || w_xfer);

    sample_fifo #(
        .WIDTH ($bits(fifo_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_accept),
        .i_wr_data (w_in_entry),
        .i_rd_en   (w_load),
        .o_rd_data (w_head),
        .o_empty   (w_fifo_empty),
        .o_level   (w_fifo_level)
    );

    // Output word register; holds steady until the memory takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_addr  <= '0;
            r_out_data  <= '0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_addr  <= w_head.addr;
            r_out_data  <= w_head.data;
        end else if (w_xfer) begin
            r_out_valid <= 1'b0;
        end
    end

    // Sticky overflow flag; a drop in the same cycle beats a clear.
    always_ff @(posedge clk) begin
        if (rst)                 r_overflow <= 1'b0;
        else if (w_drop)         r_overflow <= 1'b1;
        else if (clear_overflow) r_overflow <= 1'b0;
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_addr  = r_out_addr;
    assign bus.out_data  = r_out_data;
    assign fifo_level    = w_total;
    assign overflow      = r_overflow;

`ifdef SAMPLE_PACKER_STATS_EN
    logic [31:0] r_words_out;
    logic [15:0] r_drops;

    // Transfer and drop counters; a clear restarts them from this cycle's events.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_words_out <= '0;
            r_drops     <= '0;
        end else if (clear_overflow) begin
            r_words_out <= {31'd0, w_xfer};
            r_drops     <= {15'd0, w_drop};
        end else begin
            if (w_xfer)                       r_words_out <= r_words_out + 32'd1;
            if (w_drop && r_drops != 16'hFFFF) r_drops    <= r_drops + 16'd1;
        end
    end

    assign words_out = r_words_out;
    assign drops     = r_drops;
`endif

endmodule
